power_on_lock_bank: RTL and testbench

Parametrised bank of power-on lock bits for the security/configuration plane. Every lock comes up locked on reset. A lock opens only through a keyed request on a valid/ready interface; failed attempts are counted, and a configurable number of failures forces a permanent lockout that only reset clears. It sits between the configuration bus decoder and the protected register regions, whose write enables are gated by `locked`.

---
 rtl/power_on_lock_bank.sv | 177 +++++++++++++++++
 tb/tb_power_on_lock_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/power_on_lock_bank.sv
// power_on_lock_bank: bank of power-on lock bits opened by keyed requests.
// Optional feature macro: POWER_ON_LOCK_BANK_RELOCK_EN (enables cmd 10 relock).
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   req_valid/req_ready    request handshake
//   req_cmd/idx/key        request opcode (01 unlock, 10 relock), index, key
//   rsp_valid/rsp_ok       one-cycle response pulse and its status
//   locked                 per-lock state, 1 = locked
//   lockout                permanent lockout until reset
//   fail_count             consecutive failed unlocks, saturating
module power_on_lock_bank #(
   parameter int                NUM_LOCKS = 4,
   parameter int                KEY_W     = 16,
   parameter logic [KEY_W-1:0]  KEY_VALUE = 16'hA5C3,
   parameter int                MAX_FAIL  = 3,
   localparam int               IDX_W     = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1,
   localparam int               CNT_W     = $clog2(MAX_FAIL + 1)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_cmd,
   input  logic [IDX_W-1:0]     req_idx,
   input  logic [KEY_W-1:0]     req_key,
   output logic                 rsp_valid,
   output logic                 rsp_ok,
   output logic [NUM_LOCKS-1:0] locked,
   output logic                 lockout,
   output logic [CNT_W-1:0]     fail_count
);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      RESP,
      LOCKOUT
   } state_t;

   localparam logic [1:0] CMD_UNLOCK = 2'b01;
   localparam logic [1:0] CMD_RELOCK = 2'b10;
   localparam logic [NUM_LOCKS-1:0] ALL_LOCKED = {NUM_LOCKS{1'b1}};
   localparam logic [CNT_W-1:0]     FAIL_MAX   = CNT_W'(MAX_FAIL);

   state_t               state_q;
   state_t               state_d;

   logic [1:0]           cmd_q;
   logic [IDX_W-1:0]     idx_q;
   logic [KEY_W-1:0]     key_q;
   logic                 key_ok_q;
   logic                 idx_ok_q;

   logic                 accept;
   logic [NUM_LOCKS-1:0] sel;
   logic                 unlock_ok;
   logic                 unlock_bad;
   logic                 relock;
   logic                 hit_max;

   logic [NUM_LOCKS-1:0] locked_d;
   logic [CNT_W-1:0]     fail_d;
   logic                 lockout_d;
   logic                 rsp_valid_d;
   logic                 rsp_ok_d;
   logic                 req_ready_d;

   // req_ready is registered and high only in IDLE
   assign accept = req_valid && req_ready;

   assign sel = NUM_LOCKS'(1) << idx_q;

   assign unlock_ok  = (cmd_q == CMD_UNLOCK) && idx_ok_q && key_ok_q;
   assign unlock_bad = (cmd_q == CMD_UNLOCK) && idx_ok_q && !key_ok_q;
`ifdef POWER_ON_LOCK_BANK_RELOCK_EN
   assign relock = (cmd_q == CMD_RELOCK) && idx_ok_q;
`else
   assign relock = 1'b0;
`endif

   // Request capture and registered compare
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cmd_q    <= '0;
         idx_q    <= '0;
         key_q    <= '0;
         key_ok_q <= 1'b0;
         idx_ok_q <= 1'b0;
      end else begin
         if (state_q == IDLE && accept) begin
            cmd_q <= req_cmd;
            idx_q <= req_idx;
            key_q <= req_key;
         end
         if (state_q == CHECK) begin
            key_ok_q <= (key_q == KEY_VALUE);
            idx_ok_q <= (32'(idx_q) < NUM_LOCKS);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = CHECK;
         CHECK:   state_d = RESP;
         RESP:    state_d = hit_max ? LOCKOUT : IDLE;
         LOCKOUT: state_d = LOCKOUT;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs
   always_comb begin
      locked_d    = locked;
      fail_d      = fail_count;
      lockout_d   = lockout;
      rsp_valid_d = 1'b0;
      rsp_ok_d    = 1'b0;
      hit_max     = 1'b0;
      if (state_q == LOCKOUT) begin
         locked_d  = ALL_LOCKED;
         lockout_d = 1'b1;
      end else if (state_q == RESP) begin
         rsp_valid_d = 1'b1;
         unique case (1'b1)
            unlock_ok: begin
               rsp_ok_d = 1'b1;
               locked_d = locked & ~sel;
               fail_d   = '0;
            end
            unlock_bad: begin
               if (fail_count != FAIL_MAX)
                  fail_d = fail_count + CNT_W'(1);
               hit_max = (fail_d == FAIL_MAX);
            end
            relock: begin
               rsp_ok_d = 1'b1;
               locked_d = locked | sel;
            end
            default: ;
         endcase
      end
      req_ready_d = (state_d == IDLE);
   end

   // Output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         locked     <= ALL_LOCKED;
         fail_count <= '0;
         lockout    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_ok     <= 1'b0;
         req_ready  <= 1'b1;
      end else begin
         locked     <= locked_d;
         fail_count <= fail_d;
         lockout    <= lockout_d;
         rsp_valid  <= rsp_valid_d;
         rsp_ok     <= rsp_ok_d;
         req_ready  <= req_ready_d;
      end
   end

endmodule

// File: tb/tb_power_on_lock_bank.sv
// tb_power_on_lock_bank: directed bench for power_on_lock_bank.
// Drives a 4-lock bank and a 5-lock bank (for an out-of-range index).
module tb_power_on_lock_bank;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid = 1'b0;
   logic [1:0]  cmd = '0;
   logic [2:0]  idx = '0;
   logic [15:0] key = '0;
   logic        sel5 = 1'b0;

   always #5 clk = ~clk;

   logic       rdy4, rv4, ok4, lo4;
   logic [3:0] lk4;
   logic [1:0] fc4;
   logic       rdy5, rv5, ok5, lo5;
   logic [4:0] lk5;
   logic [1:0] fc5;

   logic       v4, v5;
   assign v4 = valid & ~sel5;
   assign v5 = valid & sel5;

   power_on_lock_bank u_dut4 (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (v4),
      .req_ready  (rdy4),
      .req_cmd    (cmd),
      .req_idx    (idx[1:0]),
      .req_key    (key),
      .rsp_valid  (rv4),
      .rsp_ok     (ok4),
      .locked     (lk4),
      .lockout    (lo4),
      .fail_count (fc4)
   );

   power_on_lock_bank #(.NUM_LOCKS(5)) u_dut5 (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (v5),
      .req_ready  (rdy5),
      .req_cmd    (cmd),
      .req_idx    (idx),
      .req_key    (key),
      .rsp_valid  (rv5),
      .rsp_ok     (ok5),
      .locked     (lk5),
      .lockout    (lo5),
      .fail_count (fc5)
   );

   logic       rdy_m, rv_m, ok_m;
   logic [4:0] lk_m;
   logic [1:0] fc_m;
   assign rdy_m = sel5 ? rdy5 : rdy4;
   assign rv_m  = sel5 ? rv5 : rv4;
   assign ok_m  = sel5 ? ok5 : ok4;
   assign lk_m  = sel5 ? lk5 : {1'b0, lk4};
   assign fc_m  = sel5 ? fc5 : fc4;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic req(input string tag, input logic [1:0] c,
                      input logic [2:0] i, input logic [15:0] k,
                      input logic eok, input logic [4:0] elk,
                      input logic [1:0] ef);
      int n;
      n = 0;
      @(negedge clk);
      while (!rdy_m && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rdy"}, 32'(rdy_m), 32'd1);
      cmd   = c;
      idx   = i;
      key   = k;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      cmd   = ~c;
      idx   = ~i;
      key   = ~k;
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_early"}, 32'(rv_m), 32'd0);
      @(negedge clk);
      chk({tag, "_rv"}, 32'(rv_m), 32'd1);
      chk({tag, "_ok"}, 32'(ok_m), 32'(eok));
      chk({tag, "_lk"}, 32'(lk_m), 32'(elk));
      chk({tag, "_fc"}, 32'(fc_m), 32'(ef));
   endtask

   logic [4:0] lk;
   logic       rl_ok;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_lk", 32'(lk4), 32'hF);
      chk("rst_lo", 32'(lo4), 32'd0);
      chk("rst_fc", 32'(fc4), 32'd0);
      chk("rst_rdy", 32'(rdy4), 32'd1);
      chk("rst_rv", 32'(rv4), 32'd0);

      lk = 5'b01011;
      req("unl2", 2'b01, 3'd2, 16'hA5C3, 1'b1, lk, 2'd0);
      req("unl2b", 2'b01, 3'd2, 16'hA5C3, 1'b1, lk, 2'd0);

`ifdef POWER_ON_LOCK_BANK_RELOCK_EN
      lk    = 5'b01111;
      rl_ok = 1'b1;
`else
      rl_ok = 1'b0;
`endif
      req("relock2", 2'b10, 3'd2, 16'h0000, rl_ok, lk, 2'd0);

      req("bad1", 2'b01, 3'd1, 16'h0000, 1'b0, lk, 2'd1);
      req("bad2", 2'b01, 3'd2, 16'h1234, 1'b0, lk, 2'd2);
      lk = lk & 5'b11110;
      req("unl0", 2'b01, 3'd0, 16'hA5C3, 1'b1, lk, 2'd0);
      req("cmd11", 2'b11, 3'd3, 16'hA5C3, 1'b0, lk, 2'd0);
      req("cmd00", 2'b00, 3'd3, 16'hA5C3, 1'b0, lk, 2'd0);

      for (int j = 1; j <= 3; j++)
         req($sformatf("lf%0d", j), 2'b01, 3'd3, 16'h0000, 1'b0, lk,
             2'(j));
      chk("lo_pulse", 32'(lo4), 32'd0);
      @(negedge clk);
      chk("lo_on", 32'(lo4), 32'd1);
      chk("lo_lk", 32'(lk4), 32'hF);
      chk("lo_rdy", 32'(rdy4), 32'd0);

      cmd   = 2'b01;
      idx   = 3'd0;
      key   = 16'hA5C3;
      valid = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk("lo_hold_rdy", 32'(rdy4), 32'd0);
         chk("lo_hold_rv", 32'(rv4), 32'd0);
      end
      valid = 1'b0;
      chk("lo_hold_lk", 32'(lk4), 32'hF);
      chk("lo_hold_fc", 32'(fc4), 32'd3);

      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst2_lo", 32'(lo4), 32'd0);
      chk("rst2_lk", 32'(lk4), 32'hF);
      chk("rst2_fc", 32'(fc4), 32'd0);
      chk("rst2_rdy", 32'(rdy4), 32'd1);

      cmd   = 2'b01;
      idx   = 3'd1;
      key   = 16'hA5C3;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("mid_lk", 32'(lk4), 32'hF);
      chk("mid_rv", 32'(rv4), 32'd0);
      chk("mid_rdy", 32'(rdy4), 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("mid_norsp", 32'(rv4), 32'd0);
      end
      chk("mid_lk2", 32'(lk4), 32'hF);
      chk("mid_rdy2", 32'(rdy4), 32'd1);

      sel5 = 1'b1;
      req("idx5", 2'b01, 3'd5, 16'hA5C3, 1'b0, 5'b11111, 2'd0);
      req("idx4", 2'b01, 3'd4, 16'hA5C3, 1'b1, 5'b01111, 2'd0);
      sel5 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
